psum_reload_ctrl: RTL and testbench
===================================

Name: psum_reload_ctrl

Overview:
- Read-side controller for the psum SRAM. It streams a completed tile of partial sums back out of the psum SRAM into the IFIFO so they can be re-accumulated in the next pass.
- Triggered by the one-cycle tile-complete pulse from the psum write counter.
- Issues sequential single-port SRAM reads and absorbs IFIFO backpressure through a one-entry hold register.
- Reports one done pulse per tile.

Parameters:
- psum_bw, 16, bits per partial sum.
- col, 8, psums per SRAM word (word width = col*psum_bw).
- ADD_WIDTH, 11, psum SRAM address width.
- TILE_LEN, 64, words read per tile (row*col); legal range 1..2^ADD_WIDTH.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- tile_ready  in  1  one-cycle pulse; a tile is complete in psum SRAM.
- base_addr  in  ADD_WIDTH  first SRAM address of the tile; sampled with tile_ready.
- sram_cen  out  1  psum SRAM chip enable, active-low.
- sram_wen  out  1  psum SRAM write enable, active-low; constant 1 (read-only).
- sram_addr  out  ADD_WIDTH  psum SRAM address.
- sram_q  in  col*psum_bw  SRAM read data; valid the cycle after a read edge.
- ififo_wr  out  1  IFIFO push request.
- ififo_full  in  1  IFIFO full; a push is accepted only when ififo_wr=1 and ififo_full=0.
- ififo_data  out  col*psum_bw  push data.
- busy  out  1  high while a tile is in flight.
- done  out  1  one-cycle pulse after the final push of a tile.
- overflow_err  out  1  sticky; a tile request was dropped.

Behaviour:
- Reset values:
  - sram_cen=1, sram_wen=1, sram_addr=0.
  - ififo_wr=0, ififo_data=0.
  - busy=0, done=0, overflow_err=0.
  - State IDLE; issue_cnt, push_cnt, hold_valid and pending all cleared.
- States:
  - IDLE: if tile_ready or pending, load cur_base (from base_addr, or pending_base if pending), clear counters and pending, go to READ.
  - READ: issue reads and accept pushes; when push_cnt reaches TILE_LEN, go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, return to IDLE. A queued pending request starts on the next cycle.
- busy=1 in READ only.
- Read issue (combinational on registered state):
  - issue = READ & issue_cnt<TILE_LEN & !hold_valid & !ififo_full.
  - sram_cen=!issue.
  - sram_addr=(cur_base+issue_cnt) mod 2^ADD_WIDTH; wrap from 2^ADD_WIDTH-1 to 0 is silent.
  - On issue, issue_cnt increments.
- Return path:
  - rd_vld register = issue delayed one edge.
  - When rd_vld=1 and ififo_full=0: ififo_wr=1, ififo_data=sram_q.
  - When rd_vld=1 and ififo_full=1: capture sram_q into hold, set hold_valid.
  - When hold_valid=1: ififo_wr=1, ififo_data=hold. When accepted, clear hold_valid.
- At most one word is in flight, because issue is gated by ififo_full and hold_valid in the same cycle. The hold register therefore never overflows, and hold and rd_vld are never both live.
- Ordering: words are pushed strictly in address order.
- Latency with no backpressure: tile_ready sampled at edge E0; first read at E1; first push accepted at E2; last push at E(TILE_LEN+1); done high during the following cycle.
- Throughput is 1 word/cycle with no backpressure.
- ififo_wr is held with stable ififo_data while ififo_full=1.
- Requests while busy or in DONE:
  - If pending=0: set pending and latch pending_base.
  - If pending=1: drop the request and set overflow_err=1, which stays set until reset.
  - A tile_ready in the same cycle as done is queued as pending, not dropped.
- Reset mid-tile: everything returns to reset values next edge. The partial tile is abandoned and pending is discarded.

Optional Feature:
- Macro: PSUM_RELOAD_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [15:0].
  - Counts cycles in READ where ififo_wr=1 and ififo_full=1.
  - Cleared on reset and at the start of each tile; saturates at 16'hFFFF.
  - Holds its value after done until the next tile starts.
- When undefined: the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- No backpressure: tile_ready with base_addr=0x040 and TILE_LEN=64, SRAM preloaded word[i]=i.
  - Required: 64 consecutive accepted pushes in order 0x040..0x07F data, first push at E2.
  - done pulses once in the cycle after E65; busy falls at the same time.
- Backpressure: hold ififo_full=1 for 5 cycles starting at the cycle of the 3rd return.
  - Required: word 3 is held stable on ififo_data with ififo_wr=1; no sram_cen=0 during the stall; no loss or duplication; done after 64 pushes.
- Wrap: base_addr=0x7F0, TILE_LEN=64.
  - Required: addresses 0x7F0..0x7FF then 0x000..0x02F, with data in that order.
- Back-to-back: second tile_ready (base 0x100) 10 cycles into the first tile.
  - Required: the second tile starts the cycle after the first done, without a further pulse; overflow_err=0.
  - A third pulse while the second is pending sets overflow_err=1, which persists after done.
- Reset mid-tile after 20 pushes.
  - Required: next cycle has busy=0, sram_cen=1, ififo_wr=0, no done; a fresh tile_ready then completes normally with 64 pushes.

Source files
------------

// File: rtl/psum_reload_ctrl.sv
// Streams a completed psum tile from the single-port psum SRAM into the IFIFO for re-accumulation.
// Define PSUM_RELOAD_STALL_CNT_EN to add the stall_cnt backpressure counter output.
module psum_reload_ctrl #(
  parameter int unsigned psum_bw   = 16,
  parameter int unsigned col       = 8,
  parameter int unsigned ADD_WIDTH = 11,
  parameter int unsigned TILE_LEN  = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tile_ready,
  input  logic [ADD_WIDTH-1:0]     base_addr,
  output logic                     sram_cen,
  output logic                     sram_wen,
  output logic [ADD_WIDTH-1:0]     sram_addr,
  input  logic [col*psum_bw-1:0]   sram_q,
  output logic                     ififo_wr,
  input  logic                     ififo_full,
  output logic [col*psum_bw-1:0]   ififo_data,
  output logic                     busy,
  output logic                     done,
`ifdef PSUM_RELOAD_STALL_CNT_EN
  output logic [15:0]              stall_cnt,
`endif
  output logic                     overflow_err
);

  localparam int unsigned DataW = col * psum_bw;
  // One extra bit so a tile spanning the whole address space can still be counted.
  localparam int unsigned CntW = ADD_WIDTH + 1;
  localparam logic [CntW-1:0] TileLen  = CntW'(TILE_LEN);
  localparam logic [CntW-1:0] LastPush = CntW'(TILE_LEN - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  typedef enum logic [1:0] {StIdle, StRead, StDone} state_e;

  state_e               state_q, state_d;
  logic [ADD_WIDTH-1:0] cur_base_q;
  logic [CntW-1:0]      issue_cnt_q;
  logic [CntW-1:0]      push_cnt_q;
  logic                 rd_vld_q;
  logic                 hold_valid_q;
  logic [DataW-1:0]     hold_q;
  logic                 pending_q;
  logic [ADD_WIDTH-1:0] pending_base_q;
  logic                 overflow_err_q;

  logic                 start;
  logic [ADD_WIDTH-1:0] start_base;
  logic                 req_queue;
  logic                 issue;
  logic                 accept;

  always_comb begin
    start      = (state_q == StIdle) && (tile_ready || pending_q);
    start_base = pending_q ? pending_base_q : base_addr;
    // In IDLE a pending request is consumed this cycle, so a new pulse takes its slot.
    req_queue  = tile_ready && ((state_q != StIdle) || pending_q);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (start) state_d = StRead;
      StRead: if (accept && (push_cnt_q == LastPush)) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs and read/push handshakes
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    issue = 1'b0;
    case (state_q)
      StRead: begin
        busy  = 1'b1;
        issue = (issue_cnt_q < TileLen) && !hold_valid_q && !ififo_full;
      end
      StDone: done = 1'b1;
      default: ;
    endcase

    sram_cen  = !issue;
    sram_wen  = 1'b1;
    sram_addr = cur_base_q + issue_cnt_q[ADD_WIDTH-1:0];

    ififo_wr   = 1'b0;
    ififo_data = '0;
    if (hold_valid_q) begin
      ififo_wr   = 1'b1;
      ififo_data = hold_q;
    end else if (rd_vld_q && !ififo_full) begin
      ififo_wr   = 1'b1;
      ififo_data = sram_q;
    end
    accept = ififo_wr && !ififo_full;
  end

  // Read issue, return path and hold register
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_base_q   <= '0;
      issue_cnt_q  <= '0;
      push_cnt_q   <= '0;
      rd_vld_q     <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      rd_vld_q <= issue;
      if (start) begin
        cur_base_q  <= start_base;
        issue_cnt_q <= '0;
        push_cnt_q  <= '0;
      end else begin
        if (issue)  issue_cnt_q <= issue_cnt_q + CntOne;
        if (accept) push_cnt_q  <= push_cnt_q + CntOne;
      end
      // Issue is gated by full and hold_valid, so the hold slot is always free here.
      if (rd_vld_q && ififo_full) begin
        hold_q       <= sram_q;
        hold_valid_q <= 1'b1;
      end else if (hold_valid_q && !ififo_full) begin
        hold_valid_q <= 1'b0;
      end
    end
  end

  // One-deep request queue and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q      <= 1'b0;
      pending_base_q <= '0;
      overflow_err_q <= 1'b0;
    end else if (req_queue) begin
      if (pending_q && (state_q != StIdle)) begin
        overflow_err_q <= 1'b1;
      end else begin
        pending_q      <= 1'b1;
        pending_base_q <= base_addr;
      end
    end else if (start && pending_q) begin
      pending_q <= 1'b0;
    end
  end

  assign overflow_err = overflow_err_q;

`ifdef PSUM_RELOAD_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (start) begin
      stall_cnt_q <= '0;
    end else if (busy && ififo_wr && ififo_full && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  // The return path and the hold register never carry a word at the same time.
  assert property (@(posedge clk) disable iff (reset) !(hold_valid_q && rd_vld_q));
  assert property (@(posedge clk) disable iff (reset) issue_cnt_q <= TileLen);

endmodule

// File: tb/tb_psum_reload_ctrl.sv
// Randomized self-checking bench for psum_reload_ctrl: in-order scoreboard, request-slot model,
// directed latency/backpressure/wrap/back-to-back/reset scenarios.
module tb_psum_reload_ctrl;

  localparam int unsigned PsumBw  = 16;
  localparam int unsigned Col     = 8;
  localparam int unsigned AddW    = 11;
  localparam int unsigned TileLen = 64;
  localparam int unsigned DataW   = PsumBw * Col;
  localparam int unsigned Depth   = 1 << AddW;

  logic             clk = 1'b0;
  logic             reset;
  logic             tile_ready;
  logic [AddW-1:0]  base_addr;
  logic             sram_cen;
  logic             sram_wen;
  logic [AddW-1:0]  sram_addr;
  logic [DataW-1:0] sram_q;
  logic             ififo_wr;
  logic             ififo_full;
  logic [DataW-1:0] ififo_data;
  logic             busy;
  logic             done;
  logic             overflow_err;
`ifdef PSUM_RELOAD_STALL_CNT_EN
  logic [15:0]      stall_cnt;
`endif

  always #5 clk = ~clk;

  psum_reload_ctrl #(
    .psum_bw  (PsumBw),
    .col      (Col),
    .ADD_WIDTH(AddW),
    .TILE_LEN (TileLen)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tile_ready  (tile_ready),
    .base_addr   (base_addr),
    .sram_cen    (sram_cen),
    .sram_wen    (sram_wen),
    .sram_addr   (sram_addr),
    .sram_q      (sram_q),
    .ififo_wr    (ififo_wr),
    .ififo_full  (ififo_full),
    .ififo_data  (ififo_data),
    .busy        (busy),
    .done        (done),
`ifdef PSUM_RELOAD_STALL_CNT_EN
    .stall_cnt   (stall_cnt),
`endif
    .overflow_err(overflow_err)
  );

  // SRAM model: data valid the cycle after a read edge, garbage otherwise.
  logic [DataW-1:0] mem [Depth];
  always @(posedge clk) begin
    if (!sram_cen) sram_q <= mem[sram_addr];
    else           sram_q <= {$urandom(), $urandom(), $urandom(), $urandom()};
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [DataW-1:0] got,
                           input logic [DataW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: tiles in flight or queued (max 2), expected reads and pushes in order.
  logic [AddW-1:0]  exp_addr_q[$];
  logic [DataW-1:0] exp_data_q[$];
  int               tiles_out;
  int               tile_pushes;
  bit               exp_done, exp_ovf, rst_seen, hold_chk, push_now, mon_en;
  logic [DataW-1:0] hold_data;

  function automatic void enqueue_tile(input logic [AddW-1:0] b);
    logic [AddW-1:0] a;
    for (int i = 0; i < TileLen; i++) begin
      a = AddW'(int'(b) + i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(mem[a]);
    end
  endfunction

  always @(negedge clk) begin
    push_now = ififo_wr && !ififo_full;
    if (mon_en) begin
      if (rst_seen) begin
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_wr", ififo_wr, 1'b0);
        check_val("rst_cen", sram_cen, 1'b1);
        check_val("rst_wen", sram_wen, 1'b1);
        check_val("rst_addr", sram_addr, '0);
        check_val("rst_data", ififo_data, '0);
        check_val("rst_ovf", overflow_err, 1'b0);
      end else begin
        check_val("done", done, exp_done);
        check_val("ovf", overflow_err, exp_ovf);
        if (done) check_val("busy_at_done", busy, 1'b0);
        if (ififo_full && !sram_cen) check_val("rd_in_stall", sram_cen, 1'b1);
        if (hold_chk) begin
          check_val("hold_wr", ififo_wr, 1'b1);
          check_val("hold_data", ififo_data, hold_data);
        end
        if (!sram_cen) begin
          if (exp_addr_q.size() == 0) check_val("rd_extra", sram_cen, 1'b1);
          else check_val("rd_addr", sram_addr, exp_addr_q.pop_front());
        end
        if (push_now) begin
          if (exp_data_q.size() == 0) check_val("push_extra", ififo_wr, 1'b0);
          else check_val("push_data", ififo_data, exp_data_q.pop_front());
        end
      end
    end
    if (reset || !mon_en) begin
      exp_addr_q.delete();
      exp_data_q.delete();
      tiles_out   = 0;
      tile_pushes = 0;
      exp_done    = 1'b0;
      exp_ovf     = 1'b0;
      hold_chk    = 1'b0;
    end else begin
      if (tile_ready) begin
        if (tiles_out < 2) begin
          tiles_out++;
          enqueue_tile(base_addr);
        end else begin
          exp_ovf = 1'b1;
        end
      end
      if (exp_done) tiles_out--;
      exp_done = 1'b0;
      if (push_now) begin
        tile_pushes++;
        if (tile_pushes == TileLen) begin
          exp_done    = 1'b1;
          tile_pushes = 0;
        end
      end
      hold_chk  = ififo_wr && ififo_full;
      hold_data = ififo_data;
    end
    rst_seen = reset;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns at E0+1, E0 being the edge that samples the pulse.
  task automatic pulse_tile(input logic [AddW-1:0] b);
    tile_ready = 1'b1;
    base_addr  = b;
    step(1);
    tile_ready = 1'b0;
    base_addr  = AddW'($urandom());
  endtask

  task automatic wait_done(input int limit, input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && k < limit) begin
      step(1);
      k++;
    end
    check_val(tag, done, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < Depth; i++)
      mem[i] = {$urandom(), $urandom(), $urandom(), 16'($urandom()), 16'(i)};
    reset      = 1'b1;
    tile_ready = 1'b0;
    base_addr  = '0;
    ififo_full = 1'b0;
    mon_en     = 1'b0;
    repeat (3) @(posedge clk);
    #1 mon_en = 1'b1;
    step(1);
    reset = 1'b0;
    step(2);

    // No backpressure: latency and throughput
    pulse_tile(11'h040);
    check_val("t1_busy", busy, 1'b1);
    check_val("t1_cen", sram_cen, 1'b0);
    check_val("t1_addr", sram_addr, 11'h040);
    check_val("t1_wr_e0", ififo_wr, 1'b0);
    step(1);
    check_val("t1_wr_e1", ififo_wr, 1'b1);
    check_val("t1_first", ififo_data, mem[11'h040]);
    step(63);
    check_val("t1_last", ififo_data, mem[11'h07F]);
    check_val("t1_done_early", done, 1'b0);
    step(1);
    check_val("t1_done", done, 1'b1);
    check_val("t1_busy_fall", busy, 1'b0);
    step(1);
    check_val("t1_done_once", done, 1'b0);
    step(2);

    // Backpressure from the 3rd return for 5 cycles
    pulse_tile(11'h200);
    step(3);
    ififo_full = 1'b1;
    step(1);
    check_val("t2_hold_wr", ififo_wr, 1'b1);
    check_val("t2_hold_data", ififo_data, mem[11'h202]);
    check_val("t2_no_rd", sram_cen, 1'b1);
    step(3);
    check_val("t2_hold_data_late", ififo_data, mem[11'h202]);
    step(1);
    ififo_full = 1'b0;
    wait_done(200, "t2_done");
`ifdef PSUM_RELOAD_STALL_CNT_EN
    check_val("t2_stall_cnt", stall_cnt, 16'd4);
`endif
    step(2);

    // Address wrap
    pulse_tile(11'h7F0);
    check_val("t3_addr0", sram_addr, 11'h7F0);
    step(16);
    check_val("t3_wrap_addr", sram_addr, 11'h000);
    check_val("t3_wrap_cen", sram_cen, 1'b0);
    wait_done(200, "t3_done");
    step(2);

    // Back-to-back, then a dropped third request
    pulse_tile(11'h300);
    step(9);
    pulse_tile(11'h100);
    check_val("t4_ovf_clear", overflow_err, 1'b0);
    step(9);
    pulse_tile(11'h180);
    check_val("t4_ovf_set", overflow_err, 1'b1);
    wait_done(200, "t4_done_a");
    step(1);
    check_val("t4_idle_busy", busy, 1'b0);
    step(1);
    check_val("t4_b_busy", busy, 1'b1);
    check_val("t4_b_cen", sram_cen, 1'b0);
    check_val("t4_b_addr", sram_addr, 11'h100);
    wait_done(200, "t4_done_b");
    step(3);
    check_val("t4_ovf_sticky", overflow_err, 1'b1);

    // Reset after 20 pushes
    pulse_tile(11'h400);
    step(21);
    reset      = 1'b1;
    ififo_full = 1'b1;
    step(1);
    check_val("t5_busy", busy, 1'b0);
    check_val("t5_cen", sram_cen, 1'b1);
    check_val("t5_wr", ififo_wr, 1'b0);
    check_val("t5_done", done, 1'b0);
    reset      = 1'b0;
    ififo_full = 1'b0;
    step(1);
    pulse_tile(11'h500);
    wait_done(200, "t5_fresh_done");
    step(2);

    // Random backpressure and request traffic
    for (int c = 0; c < 800; c++) begin
      ififo_full = ($urandom_range(0, 3) == 0);
      tile_ready = ($urandom_range(0, 99) < 2);
      base_addr  = AddW'($urandom());
      step(1);
    end
    tile_ready = 1'b0;
    ififo_full = 1'b0;
    for (int k = 0; k < 3000 && (busy || tiles_out != 0); k++) step(1);
    step(2);
    check_val("rand_drain_busy", busy, 1'b0);
    check_val("rand_drain_left", exp_data_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
